// File: rtl/jt12_wr_sched.sv
// Register-write scheduler for the jt12 CPU port: two requesters are arbitrated
// into a FIFO, and each entry is replayed as an address/data write pair with busy polling.
module jt12_wr_sched #(
    parameter int FIFO_AW = 4,
    parameter int WR_CYC  = 2,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic               a_bank,
    input  logic [7:0]         a_reg,
    input  logic [7:0]         a_data,
    input  logic               b_valid,
    output logic               b_ready,
    input  logic               b_bank,
    input  logic [7:0]         b_reg,
    input  logic [7:0]         b_data,
    output logic               ym_cs_n,
    output logic               ym_wr_n,
    output logic [1:0]         ym_addr,
    output logic [7:0]         ym_din,
    input  logic [7:0]         ym_dout,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               idle,
    output logic               timeout
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int CW    = 10;
    localparam logic [CW-1:0] WR_LAST = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_A_WR, S_A_GAP, S_A_POLL, S_D_WR, S_D_GAP, S_D_POLL
    } state_t;

    typedef struct packed {
        logic       bank;
        logic [7:0] rg;
        logic [7:0] data;
    } entry_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    entry_t             mem [DEPTH];
    entry_t             work_q, work_d, push_entry;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   level_d;
    logic               full_q, last_b_q;
    logic               push, pop, to_d, idle_d;
    logic               cs_n_d, wr_n_d;
    logic [1:0]         addr_d;
    logic [7:0]         din_d;
    logic               busy;
    logic               unused_dout;

    assign busy        = ym_dout[7];
    assign unused_dout = &{1'b0, ym_dout[6:0]};

    // Round-robin: on a tie the requester that did not win last time is granted.
    assign a_ready    = !full_q && a_valid && (!b_valid || last_b_q);
    assign b_ready    = !full_q && b_valid && (!a_valid || !last_b_q);
    assign push       = a_ready || b_ready;
    assign push_entry = a_ready ? entry_t'{a_bank, a_reg, a_data}
                                : entry_t'{b_bank, b_reg, b_data};

    // NOTE: the FIFO storage is deliberately not reset; only pointers and level are.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        state_d = state_q;
        pop     = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE:   if (fifo_level != '0) begin
                          pop     = 1'b1;
                          state_d = S_A_WR;
                      end
            S_A_WR:   if (cnt_q == WR_LAST)  state_d = S_A_GAP;
            S_A_GAP:  if (cnt_q == GAP_LAST) state_d = S_A_POLL;
            S_A_POLL: if (!busy) state_d = S_D_WR;
                      else if (cnt_q == TO_LAST) begin
                          state_d = S_D_WR;
                          to_d    = 1'b1;
                      end
            S_D_WR:   if (cnt_q == WR_LAST)  state_d = S_D_GAP;
            S_D_GAP:  if (cnt_q == GAP_LAST) state_d = S_D_POLL;
            S_D_POLL: if (!busy) state_d = S_IDLE;
                      else if (cnt_q == TO_LAST) begin
                          state_d = S_IDLE;
                          to_d    = 1'b1;
                      end
            default:  state_d = S_IDLE;
        endcase
        cnt_d   = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
        work_d  = pop ? mem[rd_ptr] : work_q;
        level_d = fifo_level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        idle_d  = (state_d == S_IDLE) && (level_d == '0);
    end

    // Output logic, computed from the next state so the registered pins line up with it.
    always_comb begin
        cs_n_d = 1'b1;
        wr_n_d = 1'b1;
        addr_d = ym_addr;
        din_d  = ym_din;
        case (state_d)
            S_A_WR, S_A_POLL: begin
                cs_n_d = 1'b0;
                wr_n_d = (state_d != S_A_WR);
                addr_d = {work_d.bank, 1'b0};
                din_d  = work_d.rg;
            end
            S_D_WR, S_D_POLL: begin
                cs_n_d = 1'b0;
                wr_n_d = (state_d != S_D_WR);
                addr_d = {work_d.bank, 1'b1};
                din_d  = work_d.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            full_q     <= 1'b0;
            last_b_q   <= 1'b1;
            ym_cs_n    <= 1'b1;
            ym_wr_n    <= 1'b1;
            ym_addr    <= '0;
            ym_din     <= '0;
            idle       <= 1'b1;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            fifo_level <= level_d;
            full_q     <= (level_d == (FIFO_AW+1)'(DEPTH));
            if (push)    wr_ptr   <= wr_ptr + 1'b1;
            if (pop)     rd_ptr   <= rd_ptr + 1'b1;
            if (a_ready) last_b_q <= 1'b0;
            else if (b_ready) last_b_q <= 1'b1;
            ym_cs_n    <= cs_n_d;
            ym_wr_n    <= wr_n_d;
            ym_addr    <= addr_d;
            ym_din     <= din_d;
            idle       <= idle_d;
            timeout    <= to_d;
        end
    end

endmodule

// File: tb/tb_jt12_wr_sched.sv
// Directed bench for jt12_wr_sched with a simple chip model that reports busy
// for 20 cycles after each write strobe (or permanently when stuck is set).
module tb_jt12_wr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, a_bank = 1'b0, b_valid = 1'b0, b_bank = 1'b0;
    logic [7:0] a_reg = '0, a_data = '0, b_reg = '0, b_data = '0;
    logic       a_ready, b_ready, ym_cs_n, ym_wr_n, idle, timeout;
    logic [1:0] ym_addr;
    logic [7:0] ym_din;
    logic [7:0] ym_dout = '0;
    logic [4:0] fifo_level;

    int total = 0;
    int bad   = 0;

    jt12_wr_sched dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_bank(a_bank), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_bank(b_bank), .b_reg(b_reg), .b_data(b_data),
        .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n), .ym_addr(ym_addr), .ym_din(ym_din),
        .ym_dout(ym_dout), .fifo_level(fifo_level), .idle(idle), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Chip model: updated on the falling edge so the DUT samples a settled status.
    int busy_cnt = 0;
    bit stuck = 1'b0;
    always @(negedge clk) begin
        if (!ym_cs_n && !ym_wr_n) busy_cnt = 20;
        else if (busy_cnt > 0)    busy_cnt = busy_cnt - 1;
        ym_dout = {(stuck || busy_cnt != 0), 7'h00};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic       cs_n;
        logic       wr_n;
        logic [1:0] addr;
        logic [7:0] din;
        int         len;
    } seg_t;

    seg_t segs[$];

    task automatic push_one(input bit use_b, input logic bank, input logic [7:0] r, input logic [7:0] d);
        @(negedge clk);
        if (use_b) begin b_valid = 1'b1; b_bank = bank; b_reg = r; b_data = d; end
        else       begin a_valid = 1'b1; a_bank = bank; a_reg = r; a_data = d; end
        #1 check(use_b ? "b_ready" : "a_ready", use_b ? b_ready : a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Run-length log of the bus pins from the first chip select until idle returns.
    task automatic capture_txn(input int budget, output bit done);
        seg_t cur;
        bit   started = 1'b0;
        cur  = '{1'b1, 1'b1, 2'b00, 8'h00, 0};
        done = 1'b0;
        segs.delete();
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!started) begin
                if (!ym_cs_n) begin
                    started = 1'b1;
                    cur = '{ym_cs_n, ym_wr_n, ym_addr, ym_din, 1};
                end
            end else if (idle) begin
                segs.push_back(cur);
                done = 1'b1;
            end else if ({ym_cs_n, ym_wr_n, ym_addr, ym_din} == {cur.cs_n, cur.wr_n, cur.addr, cur.din}) begin
                cur.len++;
            end else begin
                segs.push_back(cur);
                cur = '{ym_cs_n, ym_wr_n, ym_addr, ym_din, 1};
            end
        end
    endtask

    task automatic check_txn(input string nm, input bit done, input logic bank,
                             input logic [7:0] r, input logic [7:0] d, input int poll);
        seg_t e[6];
        e[0] = '{1'b0, 1'b0, {bank, 1'b0}, r, 2};
        e[1] = '{1'b1, 1'b1, {bank, 1'b0}, r, 4};
        e[2] = '{1'b0, 1'b1, {bank, 1'b0}, r, poll};
        e[3] = '{1'b0, 1'b0, {bank, 1'b1}, d, 2};
        e[4] = '{1'b1, 1'b1, {bank, 1'b1}, d, 4};
        e[5] = '{1'b0, 1'b1, {bank, 1'b1}, d, poll};
        check({nm, "_done"}, done, 1);
        check({nm, "_nseg"}, segs.size(), 6);
        for (int i = 0; i < 6 && i < segs.size(); i++) begin
            check($sformatf("%s_seg%0d_pins", nm, i),
                  {segs[i].cs_n, segs[i].wr_n, segs[i].addr, segs[i].din},
                  {e[i].cs_n, e[i].wr_n, e[i].addr, e[i].din});
            check($sformatf("%s_seg%0d_len", nm, i), segs[i].len, e[i].len);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (idle) seen = 1'b1;
        end
        check(tag, seen, 1);
    endtask

    initial begin
        bit   done, found, got;
        int   n, k, accepted;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs_n", ym_cs_n, 1);
        check("rst_wr_n", ym_wr_n, 1);
        check("rst_addr", ym_addr, 0);
        check("rst_din", ym_din, 0);
        check("rst_level", fifo_level, 0);
        check("rst_idle", idle, 1);
        check("rst_timeout", timeout, 0);
        check("rst_a_ready", a_ready, 0);

        // Test 1: single write from A, bank 0
        push_one(1'b0, 1'b0, 8'h28, 8'hF0);
        capture_txn(200, done);
        check_txn("t1", done, 1'b0, 8'h28, 8'hF0, 16);
        check("t1_level", fifo_level, 0);

        // Test 6: write from B, bank 1
        push_one(1'b1, 1'b1, 8'hB4, 8'hC0);
        capture_txn(200, done);
        check_txn("t6", done, 1'b1, 8'hB4, 8'hC0, 16);

        // Test 2: simultaneous requests alternate starting with A (B won the last grant)
        push_one(1'b1, 1'b0, 8'h01, 8'h02);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_valid = 1'b1; a_bank = 1'b0; a_reg = 8'h10 + 8'(i); a_data = 8'h20;
            b_valid = 1'b1; b_bank = 1'b1; b_reg = 8'h30 + 8'(i); b_data = 8'h40;
            #1;
            check($sformatf("t2_grant%0d_a", i), a_ready, (i % 2 == 0));
            check($sformatf("t2_grant%0d_b", i), b_ready, (i % 2 == 1));
            check($sformatf("t2_level%0d", i), fifo_level, i);
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("t2_level_final", fifo_level, 8);
        wait_idle("t2_drain", 1000);

        // Test 3: stuck busy, FIFO fills to 16 and stops accepting
        stuck = 1'b1;
        accepted = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a_valid = 1'b1; a_bank = 1'b0; a_reg = 8'(i); a_data = 8'(i);
            #1;
            check($sformatf("t3_level_max%0d", i), (fifo_level <= 5'd16), 1);
            if (fifo_level == 5'd16) check($sformatf("t3_full_ready%0d", i), a_ready, 0);
            if (a_ready) accepted++;
        end
        @(negedge clk);
        a_valid = 1'b0;
        check("t3_accepted", accepted, 17);
        check("t3_level_full", fifo_level, 16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t3_rst_level", fifo_level, 0);
        check("t3_rst_idle", idle, 1);

        // Test 4: stuck busy, both polls time out after 1023 cycles
        push_one(1'b0, 1'b0, 8'h30, 8'h11);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (!ym_cs_n && ym_wr_n && ym_addr == 2'b00) found = 1'b1;
        end
        check("t4_apoll_seen", found, 1);
        n = 0; got = 1'b0;
        for (int i = 0; i < 1100 && !got; i++) begin
            @(negedge clk);
            n++;
            if (timeout) got = 1'b1;
        end
        check("t4_a_to_cycles", n, 1023);
        check("t4_a_to_dwr", {ym_wr_n, ym_addr}, {1'b0, 2'b01});
        @(negedge clk);
        check("t4_pulse_width", timeout, 0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (!ym_cs_n && ym_wr_n && ym_addr == 2'b01) found = 1'b1;
        end
        check("t4_dpoll_seen", found, 1);
        n = 0; got = 1'b0;
        for (int i = 0; i < 1100 && !got; i++) begin
            @(negedge clk);
            n++;
            if (timeout) got = 1'b1;
        end
        check("t4_d_to_cycles", n, 1023);
        check("t4_d_to_idle", idle, 1);
        check("t4_d_to_cs_n", ym_cs_n, 1);
        stuck = 1'b0;

        // Test 5: reset during D_WR with 5 entries queued
        k = 0;
        for (int i = 0; i < 20 && k < 6; i++) begin
            @(negedge clk);
            a_valid = 1'b1; a_bank = 1'b0; a_reg = 8'h40 + 8'(k); a_data = 8'h50 + 8'(k);
            #1 if (a_ready) k++;
        end
        @(negedge clk);
        a_valid = 1'b0;
        check("t5_pushed", k, 6);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (!ym_wr_n && ym_addr[0]) found = 1'b1;
        end
        check("t5_dwr_seen", found, 1);
        check("t5_level_before", fifo_level, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_cs_n", ym_cs_n, 1);
        check("t5_wr_n", ym_wr_n, 1);
        check("t5_level", fifo_level, 0);
        check("t5_idle", idle, 1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!ym_cs_n || !ym_wr_n) n++;
        end
        check("t5_no_strobes", n, 0);
        check("t5_level_after", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
